maxpool_2x2: RTL

- Streaming 2x2 stride-2 max-pooling stage directly downstream of the ReLU stage.
- Consumes one signed activation per valid cycle, in raster order (row-major, one feature-map channel at a time).
- Emits one pooled value per 2x2 window.
- Keeps a half-width line buffer of horizontal pair maxima, so only one row of state is held.

---
 rtl/maxpool_2x2.sv | 122 ++++++++++++
 1 files changed

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 stride-2 max-pool over a raster-ordered activation stream.
// Optional MAXPOOL_FRAME_DONE_EN adds a frame_done pulse on the last window of each frame.
module maxpool_2x2 #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     ivalid,
    output logic signed [DATA_W-1:0] dout,
    output logic                     ovalid
`ifdef MAXPOOL_FRAME_DONE_EN
    ,
    output logic                     frame_done
`endif
);

    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int LB_N   = IMG_W / 2;
    localparam int LB_AW  = (LB_N > 1) ? $clog2(LB_N) : 1;

    if (((IMG_W % 2) != 0) || (IMG_W < 2)) begin : g_bad_img_w
        $error("maxpool_2x2: IMG_W must be even and >= 2");
    end
    if (((IMG_H % 2) != 0) || (IMG_H < 2)) begin : g_bad_img_h
        $error("maxpool_2x2: IMG_H must be even and >= 2");
    end

    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic signed [DATA_W-1:0] pair_q, pair_d;
    logic                     pair_vld_q, pair_vld_d;
    logic signed [DATA_W-1:0] dout_q, dout_d;
    logic                     ovalid_q, ovalid_d;
    logic                     fd_q, fd_d;

    // Line buffer holds the horizontal pair maxima of the last even row.
    logic signed [DATA_W-1:0] linebuf [LB_N];
    logic [LB_AW-1:0]         lb_idx;
    logic signed [DATA_W-1:0] lb_rd;
    logic signed [DATA_W-1:0] pair_max;
    logic signed [DATA_W-1:0] win_max;
    logic                     col_last, row_last;
    logic                     lb_we;

    assign lb_idx   = LB_AW'(col_q >> 1);
    assign lb_rd    = linebuf[lb_idx];
    assign pair_max = (pair_q > din) ? pair_q : din;
    assign win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;
    assign col_last = (col_q == COL_W'(IMG_W - 1));
    assign row_last = (row_q == ROW_W'(IMG_H - 1));
    assign lb_we    = ivalid && col_q[0] && pair_vld_q && !row_q[0];

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        pair_d     = pair_q;
        pair_vld_d = pair_vld_q;
        dout_d     = dout_q;
        ovalid_d   = 1'b0;
        fd_d       = 1'b0;
        if (ivalid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (!col_q[0]) begin
                pair_d     = din;
                pair_vld_d = 1'b1;
            end else begin
                pair_vld_d = 1'b0;
                if (pair_vld_q && row_q[0]) begin
                    dout_d   = win_max;
                    ovalid_d = 1'b1;
                    fd_d     = col_last && row_last;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            pair_q     <= '0;
            pair_vld_q <= 1'b0;
            dout_q     <= '0;
            ovalid_q   <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            pair_q     <= pair_d;
            pair_vld_q <= pair_vld_d;
            dout_q     <= dout_d;
            ovalid_q   <= ovalid_d;
            fd_q       <= fd_d;
        end
    end

    // No reset: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[lb_idx] <= pair_max;
        end
    end

    assign dout   = dout_q;
    assign ovalid = ovalid_q;
`ifdef MAXPOOL_FRAME_DONE_EN
    assign frame_done = fd_q;
`else
    logic unused_fd;
    assign unused_fd = fd_q;
`endif

endmodule
